reg_writeback_arbiter: RTL and testbench

Write-side sequencer for the 32x32 register file: merges single-cycle ALU results and multi-cycle memory/load results onto the file's single write port (reg_write_en / reg_write_dest / reg_write_data). ALU results have priority; memory results are buffered in a small FIFO and drained in idle write slots. It also reports pending-write hazards for the two read addresses so decode can stall.

---
 rtl/wb_pkg.sv | 19 +
 rtl/reg_writeback_arbiter_if.sv | 45 ++++
 rtl/wb_fifo.sv | 74 +++++++
 rtl/reg_writeback_arbiter.sv | 115 +++++++++++
 tb/tb_reg_writeback_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the buffered write-back entry format for the register
// file write-side sequencer.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_real_dest(input logic [REG_ADDR_W-1:0] dest);
    return dest != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Bundle of the ALU/memory result handshakes, register-file write port and
// hazard lookup seen by the write-back arbiter.
interface reg_writeback_arbiter_if;
  import wb_pkg::*;

  logic                  alu_wb_valid;
  logic [REG_ADDR_W-1:0] alu_wb_dest;
  logic [REG_DATA_W-1:0] alu_wb_data;
  logic                  alu_wb_stall;

  logic                  mem_wb_valid;
  logic                  mem_wb_ready;
  logic [REG_ADDR_W-1:0] mem_wb_dest;
  logic [REG_DATA_W-1:0] mem_wb_data;

  logic                  reg_write_en;
  logic [REG_ADDR_W-1:0] reg_write_dest;
  logic [REG_DATA_W-1:0] reg_write_data;

  logic [REG_ADDR_W-1:0] reg_read_addr_1;
  logic [REG_ADDR_W-1:0] reg_read_addr_2;
  logic                  pend_hit_1;
  logic                  pend_hit_2;

  modport master (
    output alu_wb_valid, alu_wb_dest, alu_wb_data,
    input  alu_wb_stall,
    output mem_wb_valid, mem_wb_dest, mem_wb_data,
    input  mem_wb_ready,
    input  reg_write_en, reg_write_dest, reg_write_data,
    output reg_read_addr_1, reg_read_addr_2,
    input  pend_hit_1, pend_hit_2
  );

  modport slave (
    input  alu_wb_valid, alu_wb_dest, alu_wb_data,
    output alu_wb_stall,
    input  mem_wb_valid, mem_wb_dest, mem_wb_data,
    output mem_wb_ready,
    output reg_write_en, reg_write_dest, reg_write_data,
    input  reg_read_addr_1, reg_read_addr_2,
    output pend_hit_1, pend_hit_2
  );

endinterface

// File: rtl/wb_fifo.sv
// Memory-result buffer: circular storage with per-entry live bits that can be
// squashed by destination, plus per-entry destination match for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_dest,
  input  logic [REG_ADDR_W-1:0] lookup_addr_1,
  input  logic [REG_ADDR_W-1:0] lookup_addr_2,
  output logic [DEPTH-1:0]      match_1,
  output logic [DEPTH-1:0]      match_2
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  assign wr_idx  = wr_ptr[PTR_W-1:0];
  assign rd_idx  = rd_ptr[PTR_W-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign head    = mem_q[rd_idx];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Live bits double as occupancy: popped and reset slots are never live, so
  // the match vectors need no separate valid mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i].live <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && mem_q[i].dest == squash_dest) mem_q[i].live <= 1'b0;
        if (do_pop && PTR_W'(i) == rd_idx) mem_q[i].live <= 1'b0;
        if (do_push && PTR_W'(i) == wr_idx) begin
          mem_q[i].live <= push_entry.live &&
                           !(squash_en && push_entry.dest == squash_dest);
          mem_q[i].dest <= push_entry.dest;
          mem_q[i].data <= push_entry.data;
        end
      end
    end
  end

  always_comb begin
    match_1 = '0;
    match_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_1[i] = mem_q[i].live && (mem_q[i].dest == lookup_addr_1);
      match_2[i] = mem_q[i].live && (mem_q[i].dest == lookup_addr_2);
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and buffered memory results onto the single register-file write
// port, with starvation relief for the memory side and read hazard reporting.
module reg_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic                    clk,
  input logic                    rst,
  reg_writeback_arbiter_if.slave wb
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  alu_win;
  logic                  push;
  logic                  pop;
  logic [DEPTH-1:0]      match_1;
  logic [DEPTH-1:0]      match_2;

  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_cnt_next;
  logic                  stall_q;
  logic                  stall_next;

  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_dest_q;
  logic [REG_DATA_W-1:0] wr_data_q;
  logic                  wr_en_next;
  logic [REG_ADDR_W-1:0] wr_dest_next;
  logic [REG_DATA_W-1:0] wr_data_next;

  assign alu_win         = wb.alu_wb_valid && is_real_dest(wb.alu_wb_dest);
  assign pop             = !alu_win && !fifo_empty;
  assign wb.mem_wb_ready = !fifo_full && !rst;
  assign push            = wb.mem_wb_valid && wb.mem_wb_ready;

  assign push_entry.live = is_real_dest(wb.mem_wb_dest);
  assign push_entry.dest = wb.mem_wb_dest;
  assign push_entry.data = wb.mem_wb_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_entry    (push_entry),
    .pop           (pop),
    .head          (head),
    .empty         (fifo_empty),
    .full          (fifo_full),
    .squash_en     (alu_win),
    .squash_dest   (wb.alu_wb_dest),
    .lookup_addr_1 (wb.reg_read_addr_1),
    .lookup_addr_2 (wb.reg_read_addr_2),
    .match_1       (match_1),
    .match_2       (match_2)
  );

  // The stall cycle itself always ends the starvation run, even if the ALU
  // ignores the stall and wins again.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (stall_q || fifo_empty || pop) starve_cnt_next = '0;
    else if (alu_win)                 starve_cnt_next = starve_cnt + 1'b1;
    stall_next = (starve_cnt_next == CNT_W'(STARVE_MAX));
  end

  always_comb begin
    wr_en_next   = 1'b0;
    wr_dest_next = REG_ZERO;
    wr_data_next = '0;
    if (alu_win) begin
      wr_en_next   = 1'b1;
      wr_dest_next = wb.alu_wb_dest;
      wr_data_next = wb.alu_wb_data;
    end else if (pop && head.live && is_real_dest(head.dest)) begin
      wr_en_next   = 1'b1;
      wr_dest_next = head.dest;
      wr_data_next = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_dest_q  <= REG_ZERO;
      wr_data_q  <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
      stall_q    <= stall_next;
      wr_en_q    <= wr_en_next;
      wr_dest_q  <= wr_dest_next;
      wr_data_q  <= wr_data_next;
    end
  end

  assign wb.alu_wb_stall   = stall_q;
  assign wb.reg_write_en   = wr_en_q;
  assign wb.reg_write_dest = wr_dest_q;
  assign wb.reg_write_data = wr_data_q;

  // A write sitting in the output register has not reached the file yet.
  assign wb.pend_hit_1 = is_real_dest(wb.reg_read_addr_1) &&
                         ((|match_1) || (wr_en_q && wr_dest_q == wb.reg_read_addr_1));
  assign wb.pend_hit_2 = is_real_dest(wb.reg_read_addr_2) &&
                         ((|match_2) || (wr_en_q && wr_dest_q == wb.reg_read_addr_2));

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the write-back arbiter.
module tb_reg_writeback_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct {
    bit        live;
    bit [4:0]  dest;
    bit [31:0] data;
  } ment_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_writeback_arbiter_if bus();

  reg_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.alu_wb_valid    = 1'b0;
    bus.alu_wb_dest     = 5'd0;
    bus.alu_wb_data     = 32'd0;
    bus.mem_wb_valid    = 1'b0;
    bus.mem_wb_dest     = 5'd0;
    bus.mem_wb_data     = 32'd0;
    bus.reg_read_addr_1 = 5'd0;
    bus.reg_read_addr_2 = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.mem_wb_valid    = 1'b1;
    bus.mem_wb_dest     = 5'd7;
    bus.mem_wb_data     = 32'hdead_beef;
    bus.reg_read_addr_1 = 5'd7;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.reg_write_en !== 1'b0 || bus.reg_write_dest !== 5'd0 ||
          bus.reg_write_data !== 32'd0 || bus.alu_wb_stall !== 1'b0 ||
          bus.mem_wb_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: en=%0b dest=%0d data=%0h stall=%0b ready=%0b, required all 0",
                 bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data,
                 bus.alu_wb_stall, bus.mem_wb_ready);
      end
    end
    rst = 1'b0;
    bus.mem_wb_valid = 1'b0;
    #1;
    checks++;
    if (bus.mem_wb_ready !== 1'b1 || bus.pend_hit_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0b pend_hit_1=%0b, required ready=1 pend_hit_1=0",
               bus.mem_wb_ready, bus.pend_hit_1);
    end
    step();
    checks++;
    if (bus.reg_write_en !== 1'b0 || bus.pend_hit_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_nothing_enqueued: en=%0b pend_hit_1=%0b, required 0 0",
               bus.reg_write_en, bus.pend_hit_1);
    end
  endtask

  task automatic test_alu_only();
    idle_inputs();
    bus.alu_wb_valid    = 1'b1;
    bus.alu_wb_dest     = 5'd3;
    bus.alu_wb_data     = 32'd10;
    bus.reg_read_addr_1 = 5'd3;
    step();
    bus.alu_wb_valid = 1'b0;
    #1;
    checks++;
    if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd3 ||
        bus.reg_write_data !== 32'd10 || bus.pend_hit_1 !== 1'b1) begin
      errors++;
      $display("FAIL alu_write: en=%0b dest=%0d data=%0d hit=%0b, required 1 3 10 1",
               bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pend_hit_1);
    end
    step();
    checks++;
    if (bus.reg_write_en !== 1'b0 || bus.pend_hit_1 !== 1'b0) begin
      errors++;
      $display("FAIL alu_single_cycle: en=%0b hit=%0b, required 0 0",
               bus.reg_write_en, bus.pend_hit_1);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    bus.mem_wb_valid    = 1'b1;
    bus.mem_wb_dest     = 5'd5;
    bus.mem_wb_data     = 32'd7;
    bus.alu_wb_valid    = 1'b1;
    bus.alu_wb_dest     = 5'd6;
    bus.alu_wb_data     = 32'd9;
    bus.reg_read_addr_1 = 5'd5;
    step();
    bus.mem_wb_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) bus.alu_wb_valid = 1'b0;
      #1;
      checks++;
      if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd6 ||
          bus.reg_write_data !== 32'd9 || bus.pend_hit_1 !== 1'b1) begin
        errors++;
        $display("FAIL priority_alu_%0d: en=%0b dest=%0d data=%0d hit5=%0b, required 1 6 9 1",
                 k, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pend_hit_1);
      end
      step();
    end
    checks++;
    if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd5 ||
        bus.reg_write_data !== 32'd7 || bus.pend_hit_1 !== 1'b1) begin
      errors++;
      $display("FAIL priority_mem: en=%0b dest=%0d data=%0d hit5=%0b, required 1 5 7 1",
               bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pend_hit_1);
    end
    step();
    checks++;
    if (bus.reg_write_en !== 1'b0 || bus.pend_hit_1 !== 1'b0) begin
      errors++;
      $display("FAIL priority_done: en=%0b hit5=%0b, required 0 0",
               bus.reg_write_en, bus.pend_hit_1);
    end
  endtask

  task automatic test_squash();
    idle_inputs();
    bus.mem_wb_valid    = 1'b1;
    bus.mem_wb_dest     = 5'd4;
    bus.mem_wb_data     = 32'd1;
    bus.reg_read_addr_1 = 5'd4;
    step();
    bus.mem_wb_valid = 1'b0;
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_dest  = 5'd4;
    bus.alu_wb_data  = 32'd2;
    #1;
    checks++;
    if (bus.pend_hit_1 !== 1'b1 || bus.reg_write_en !== 1'b0) begin
      errors++;
      $display("FAIL squash_pending: hit4=%0b en=%0b, required 1 0",
               bus.pend_hit_1, bus.reg_write_en);
    end
    step();
    bus.alu_wb_valid = 1'b0;
    #1;
    checks++;
    if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd4 ||
        bus.reg_write_data !== 32'd2) begin
      errors++;
      $display("FAIL squash_alu_write: en=%0b dest=%0d data=%0d, required 1 4 2",
               bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (bus.reg_write_en !== 1'b0 || bus.pend_hit_1 !== 1'b0) begin
        errors++;
        $display("FAIL squash_dead_pop_%0d: en=%0b data=%0d hit4=%0b, required en=0 hit4=0",
                 k, bus.reg_write_en, bus.reg_write_data, bus.pend_hit_1);
      end
    end
    // Same-cycle squash: memory entry enqueued with a matching ALU write.
    bus.mem_wb_valid = 1'b1;
    bus.mem_wb_data  = 32'd3;
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_data  = 32'd5;
    step();
    idle_inputs();
    bus.reg_read_addr_1 = 5'd4;
    #1;
    checks++;
    if (bus.reg_write_en !== 1'b1 || bus.reg_write_data !== 32'd5) begin
      errors++;
      $display("FAIL squash_same_cycle_alu: en=%0b data=%0d, required 1 5",
               bus.reg_write_en, bus.reg_write_data);
    end
    step();
    checks++;
    if (bus.reg_write_en !== 1'b0 || bus.pend_hit_1 !== 1'b0) begin
      errors++;
      $display("FAIL squash_same_cycle_dead: en=%0b data=%0d hit4=%0b, required en=0 hit4=0",
               bus.reg_write_en, bus.reg_write_data, bus.pend_hit_1);
    end
  endtask

  task automatic test_full_starvation();
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    idle_inputs();
    bus.alu_wb_dest = 5'd9;
    for (int k = 1; k <= STARVE_MAX + 2; k++) begin
      bus.alu_wb_data  = 32'(100 + k);
      bus.alu_wb_valid = !bus.alu_wb_stall;
      bus.mem_wb_valid = (k <= 4);
      bus.mem_wb_dest  = 5'(9 + k);
      bus.mem_wb_data  = 32'(19 + k);
      step();
      exp_dest = (k == STARVE_MAX + 2) ? 5'd10 : 5'd9;
      exp_data = (k == STARVE_MAX + 2) ? 32'd20 : 32'(100 + k);
      checks++;
      if (bus.alu_wb_stall !== (k == STARVE_MAX + 1)) begin
        errors++;
        $display("FAIL starve_stall_edge%0d: stall=%0b, required %0b",
                 k, bus.alu_wb_stall, (k == STARVE_MAX + 1));
      end
      checks++;
      if (bus.mem_wb_ready !== (k < 4 || k >= STARVE_MAX + 2)) begin
        errors++;
        $display("FAIL starve_ready_edge%0d: ready=%0b, required %0b",
                 k, bus.mem_wb_ready, (k < 4 || k >= STARVE_MAX + 2));
      end
      checks++;
      if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== exp_dest ||
          bus.reg_write_data !== exp_data) begin
        errors++;
        $display("FAIL starve_write_edge%0d: en=%0b dest=%0d data=%0d, required 1 %0d %0d",
                 k, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, exp_dest, exp_data);
      end
    end
    idle_inputs();
    for (int j = 1; j <= 3; j++) begin
      step();
      checks++;
      if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'(10 + j) ||
          bus.reg_write_data !== 32'(20 + j)) begin
        errors++;
        $display("FAIL starve_drain_%0d: en=%0b dest=%0d data=%0d, required 1 %0d %0d",
                 j, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, 10 + j, 20 + j);
      end
    end
    step();
    checks++;
    if (bus.reg_write_en !== 1'b0) begin
      errors++;
      $display("FAIL starve_drained: en=%0b, required 0", bus.reg_write_en);
    end
  endtask

  task automatic test_reg_zero();
    idle_inputs();
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_data  = 32'd55;
    bus.mem_wb_valid = 1'b1;
    bus.mem_wb_data  = 32'd66;
    step();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (bus.reg_write_en !== 1'b0 || bus.pend_hit_1 !== 1'b0 || bus.mem_wb_ready !== 1'b1) begin
        errors++;
        $display("FAIL reg_zero_%0d: en=%0b hit0=%0b ready=%0b, required 0 0 1",
                 k, bus.reg_write_en, bus.pend_hit_1, bus.mem_wb_ready);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_dest  = 5'd1;
    for (int k = 0; k < 3; k++) begin
      bus.mem_wb_valid = 1'b1;
      bus.mem_wb_dest  = 5'(20 + k);
      bus.mem_wb_data  = 32'(200 + k);
      step();
    end
    idle_inputs();
    rst = 1'b1;
    step();
    checks++;
    if (bus.reg_write_en !== 1'b0 || bus.reg_write_dest !== 5'd0 || bus.reg_write_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: en=%0b dest=%0d data=%0d, required 0 0 0",
               bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data);
    end
    rst = 1'b0;
    bus.reg_read_addr_1 = 5'd20;
    bus.reg_read_addr_2 = 5'd22;
    #1;
    checks++;
    if (bus.mem_wb_ready !== 1'b1 || bus.pend_hit_1 !== 1'b0 || bus.pend_hit_2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flushed: ready=%0b hit20=%0b hit22=%0b, required 1 0 0",
               bus.mem_wb_ready, bus.pend_hit_1, bus.pend_hit_2);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.reg_write_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_write_%0d: en=%0b dest=%0d, required en=0",
                 k, bus.reg_write_en, bus.reg_write_dest);
      end
    end
  endtask

  task automatic test_random();
    ment_t     q[$];
    ment_t     e;
    bit        m_en, m_stall, n_en, alu_w, push, popped, was_empty, h1, h2;
    bit [4:0]  m_dest, n_dest, ad, md, r1, r2;
    bit [31:0] m_data, n_data, adata, mdata;
    bit        av, mv;
    int        m_starve, prob;

    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_en = 0; m_dest = 0; m_data = 0; m_stall = 0; m_starve = 0;
    q.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 250) % 3)
        0:       prob = 30;
        1:       prob = 70;
        default: prob = 96;
      endcase
      av    = ($urandom_range(99) < prob) && !m_stall;
      ad    = 5'($urandom_range(7));
      adata = $urandom;
      mv    = ($urandom_range(99) < 50);
      md    = 5'($urandom_range(7));
      mdata = $urandom;
      r1    = 5'($urandom_range(7));
      r2    = 5'($urandom_range(7));
      bus.alu_wb_valid    = av;
      bus.alu_wb_dest     = ad;
      bus.alu_wb_data     = adata;
      bus.mem_wb_valid    = mv;
      bus.mem_wb_dest     = md;
      bus.mem_wb_data     = mdata;
      bus.reg_read_addr_1 = r1;
      bus.reg_read_addr_2 = r2;
      #1;

      h1 = 0;
      h2 = 0;
      if (r1 != 0 && m_en && m_dest == r1) h1 = 1;
      if (r2 != 0 && m_en && m_dest == r2) h2 = 1;
      foreach (q[i]) begin
        if (r1 != 0 && q[i].live && q[i].dest == r1) h1 = 1;
        if (r2 != 0 && q[i].live && q[i].dest == r2) h2 = 1;
      end

      checks++;
      if (bus.reg_write_en !== m_en ||
          (m_en && (bus.reg_write_dest !== m_dest || bus.reg_write_data !== m_data))) begin
        errors++;
        $display("FAIL rand_write cyc%0d: en=%0b dest=%0d data=%0h, required en=%0b dest=%0d data=%0h",
                 cyc, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, m_en, m_dest, m_data);
      end
      checks++;
      if (bus.alu_wb_stall !== m_stall || bus.mem_wb_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d: stall=%0b ready=%0b, required stall=%0b ready=%0b",
                 cyc, bus.alu_wb_stall, bus.mem_wb_ready, m_stall, (q.size() < DEPTH));
      end
      checks++;
      if (bus.pend_hit_1 !== h1 || bus.pend_hit_2 !== h2) begin
        errors++;
        $display("FAIL rand_hazard cyc%0d: hit1=%0b hit2=%0b (addr %0d %0d), required %0b %0b",
                 cyc, bus.pend_hit_1, bus.pend_hit_2, r1, r2, h1, h2);
      end

      was_empty = (q.size() == 0);
      alu_w     = av && (ad != 0);
      push      = mv && (q.size() < DEPTH);
      popped    = 0;
      n_en      = 0;
      n_dest    = 0;
      n_data    = 0;
      if (alu_w) begin
        foreach (q[i]) if (q[i].dest == ad) q[i].live = 0;
        n_en   = 1;
        n_dest = ad;
        n_data = adata;
      end else if (!was_empty) begin
        e      = q.pop_front();
        popped = 1;
        if (e.live && e.dest != 0) begin
          n_en   = 1;
          n_dest = e.dest;
          n_data = e.data;
        end
      end
      if (push) begin
        e.live = (md != 0) && !(alu_w && ad == md);
        e.dest = md;
        e.data = mdata;
        q.push_back(e);
      end
      if (m_stall || was_empty || popped) m_starve = 0;
      else                                m_starve++;
      m_stall = (m_starve == STARVE_MAX);
      m_en    = n_en;
      m_dest  = n_dest;
      m_data  = n_data;

      step();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_only();
    test_priority();
    test_squash();
    test_full_starvation();
    test_reg_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
